// File: rtl/user_code_loader_pkg.sv
// Shared definitions for the i281 runtime code loader: state encodings,
// default frame delimiter and code image geometry.
package user_code_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HI     = 3'd1,
      ST_LO     = 3'd2,
      ST_CHK    = 3'd3,
      ST_COMMIT = 3'd4
   } state_t;

   localparam logic [7:0] DEFAULT_START_BYTE = 8'hA5;
   localparam int CODE_WORDS = 16;
   localparam int WORD_W     = 16;
   localparam int IDX_W      = 4;
   localparam int IMAGE_W    = CODE_WORDS * WORD_W;

   // States in which a frame is in flight and the inter-byte timeout runs.
   function automatic logic is_frame_state(input state_t s);
      return (s == ST_HI) || (s == ST_LO) || (s == ST_CHK);
   endfunction

endpackage

// File: rtl/user_code_loader_code_image_reg.sv
// Shadow/active instruction register bank: byte-wise writes into the shadow
// copy, single-edge bulk copy of the whole shadow into the active image.
module code_image_reg
   import user_code_loader_pkg::*;
(
   input  logic               clock,
   input  logic               reset_n,
   input  logic               wr_en,
   input  logic               wr_hi,
   input  logic [IDX_W-1:0]   wr_idx,
   input  logic [7:0]         wr_byte,
   input  logic               commit,
   output logic [IMAGE_W-1:0] image
);

   logic [CODE_WORDS-1:0][WORD_W-1:0] shadow;
   logic [CODE_WORDS-1:0][WORD_W-1:0] active;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         shadow <= '0;
      end else if (wr_en) begin
         if (wr_hi) shadow[wr_idx][15:8] <= wr_byte;
         else       shadow[wr_idx][7:0]  <= wr_byte;
      end
   end

   // The CPU must never see a half-updated program, so all words move together.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)    active <= '0;
      else if (commit) active <= shadow;
   end

   assign image = active;

endmodule

// File: rtl/user_code_loader.sv
// Framed byte-stream loader for the i281 instruction store: assembles a
// 16-word program in a shadow buffer and commits it after a good checksum.
module user_code_loader
   import user_code_loader_pkg::*;
#(
   parameter logic [7:0] START_BYTE     = DEFAULT_START_BYTE,
   parameter int         TIMEOUT_CYCLES = 1024
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [7:0]         in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [IMAGE_W-1:0] code_image,
   output logic               cpu_hold,
   output logic               load_done,
   output logic               load_err
);

   localparam int TCNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 10) ? $clog2(TIMEOUT_CYCLES + 1) : 10;
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

   state_t              state, state_next;
   logic [7:0]          acc;
   logic [IDX_W-1:0]    idx;
   logic [TCNT_W-1:0]   tcnt;
   logic                xfer, in_frame, timeout;
   logic                frame_start, shadow_we, shadow_hi, idx_inc, commit, err_set;

   assign in_ready = (state != ST_COMMIT);
   assign xfer     = in_valid && in_ready;
   assign in_frame = is_frame_state(state);
   // Fires on the idle cycle that would bring the counter to TIMEOUT_CYCLES;
   // a transfer in that same cycle takes priority.
   assign timeout  = in_frame && !xfer && (tcnt == TCNT_LAST);
   assign cpu_hold = (state != ST_IDLE);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next  = state;
      frame_start = 1'b0;
      shadow_we   = 1'b0;
      shadow_hi   = 1'b0;
      idx_inc     = 1'b0;
      commit      = 1'b0;
      err_set     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (xfer && (in_data == START_BYTE)) begin
               frame_start = 1'b1;
               state_next  = ST_HI;
            end
         end
         ST_HI: begin
            if (xfer) begin
               shadow_we  = 1'b1;
               shadow_hi  = 1'b1;
               state_next = ST_LO;
            end else if (timeout) begin
               err_set    = 1'b1;
               state_next = ST_IDLE;
            end
         end
         ST_LO: begin
            if (xfer) begin
               shadow_we = 1'b1;
               if (idx == IDX_W'(CODE_WORDS - 1)) begin
                  state_next = ST_CHK;
               end else begin
                  idx_inc    = 1'b1;
                  state_next = ST_HI;
               end
            end else if (timeout) begin
               err_set    = 1'b1;
               state_next = ST_IDLE;
            end
         end
         ST_CHK: begin
            if (xfer) begin
               if (in_data == acc) begin
                  state_next = ST_COMMIT;
               end else begin
                  err_set    = 1'b1;
                  state_next = ST_IDLE;
               end
            end else if (timeout) begin
               err_set    = 1'b1;
               state_next = ST_IDLE;
            end
         end
         ST_COMMIT: begin
            commit     = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         acc       <= '0;
         idx       <= '0;
         tcnt      <= '0;
         load_err  <= 1'b0;
         load_done <= 1'b0;
      end else begin
         load_done <= commit;
         if (frame_start) begin
            acc <= '0;
            idx <= '0;
         end else begin
            if (shadow_we) acc <= acc ^ in_data;
            if (idx_inc)   idx <= idx + 1'b1;
         end
         if (in_frame && !xfer && !timeout) tcnt <= tcnt + 1'b1;
         else                               tcnt <= '0;
         if (frame_start)  load_err <= 1'b0;
         else if (err_set) load_err <= 1'b1;
      end
   end

   code_image_reg u_image (
      .clock   (clock),
      .reset_n (reset_n),
      .wr_en   (shadow_we),
      .wr_hi   (shadow_hi),
      .wr_idx  (idx),
      .wr_byte (in_data),
      .commit  (commit),
      .image   (code_image)
   );

endmodule

// File: tb/tb_user_code_loader.sv
// Self-checking bench for user_code_loader: table of frames plus hand-written
// timeout, back-to-back and asynchronous-reset sequences.
module tb_user_code_loader;

   localparam int          T     = 1024;
   localparam logic [7:0]  START = 8'hA5;

   logic         clock;
   logic         reset_n;
   logic [7:0]   in_data;
   logic         in_valid;
   logic         in_ready;
   logic [255:0] code_image;
   logic         cpu_hold;
   logic         load_done;
   logic         load_err;

   user_code_loader #(.START_BYTE(START), .TIMEOUT_CYCLES(T)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .code_image (code_image),
      .cpu_hold   (cpu_hold),
      .load_done  (load_done),
      .load_err   (load_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [15:0] base;
      logic [7:0]  csum_xor;
      int          garbage;
      bit          exp_ok;
   } vec_t;

   int           total = 0;
   int           bad   = 0;
   logic [7:0]   fb [34];
   logic [255:0] model_img;
   logic [255:0] exp_q [$];

   // Monitor: observed commits and cpu_hold occupancy.
   int           hold_cnt = 0;
   int           obs_n    = 0;
   int           obs_rd   = 0;
   logic [255:0] obs_img [64];

   always @(negedge clock) begin
      hold_cnt <= hold_cnt + int'(cpu_hold);
      if (load_done) begin
         obs_img[obs_n & 63] <= code_image;
         obs_n <= obs_n + 1;
      end
   end

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] img_of(input logic [15:0] base);
      logic [255:0] r;
      r = '0;
      for (int k = 0; k < 16; k++) r[16*k +: 16] = base + 16'(k);
      return r;
   endfunction

   task automatic make_frame(input logic [15:0] base, input logic [7:0] csum_xor);
      logic [7:0]  cs;
      logic [15:0] w;
      cs = 8'h00;
      fb[0] = START;
      for (int k = 0; k < 16; k++) begin
         w = base + 16'(k);
         fb[1 + 2*k] = w[15:8];
         fb[2 + 2*k] = w[7:0];
         cs = cs ^ w[15:8] ^ w[7:0];
      end
      fb[33] = cs ^ csum_xor;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int   guard;
      logic took;
      guard = 0;
      in_data  = b;
      in_valid = 1'b1;
      do begin
         took = in_ready;
         @(posedge clock); #1;
         guard++;
      end while (!took && guard < 8);
      if (!took) begin
         total++;
         bad++;
         $display("FAIL send_byte: byte %0h not accepted within %0d cycles", b, guard);
      end
   endtask

   task automatic send_range(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) send_byte(fb[i]);
   endtask

   task automatic sb_check(input string name);
      chk({name, "_count"}, 256'(obs_n - obs_rd), 256'(exp_q.size()));
      while (obs_rd < obs_n && exp_q.size() > 0) begin
         chk({name, "_image"}, obs_img[obs_rd & 63], exp_q.pop_front());
         obs_rd++;
      end
      exp_q.delete();
      obs_rd = obs_n;
   endtask

   task automatic run_vec(input string name, input vec_t v);
      int h0;
      for (int g = 0; g < v.garbage; g++) begin
         send_byte((g % 2) ? 8'hFF : 8'h00);
         chk({name, "_garbage_hold"}, 256'(cpu_hold), 256'(0));
      end
      make_frame(v.base, v.csum_xor);
      h0 = hold_cnt;
      send_byte(fb[0]);
      chk({name, "_err_clear"}, 256'(load_err), 256'(0));
      send_range(1, 33);
      if (v.exp_ok) exp_q.push_back(img_of(v.base));
      in_valid = 1'b0;
      chk({name, "_ready_after_chk"}, 256'(in_ready), 256'(!v.exp_ok));
      chk({name, "_err"}, 256'(load_err), 256'(!v.exp_ok));
      @(posedge clock); #1;
      chk({name, "_done_pulse"}, 256'(load_done), 256'(v.exp_ok));
      chk({name, "_word5"}, 256'(code_image[95:80]),
          256'(v.exp_ok ? v.base + 16'd5 : model_img[95:80]));
      @(posedge clock); #1;
      chk({name, "_done_low"}, 256'(load_done), 256'(0));
      chk({name, "_hold_cycles"}, 256'(hold_cnt - h0), 256'(v.exp_ok ? 34 : 33));
      if (v.exp_ok) model_img = img_of(v.base);
      chk({name, "_image"}, code_image, model_img);
      sb_check(name);
   endtask

   vec_t vecs [4];

   initial begin
      vecs[0] = '{base: 16'h1000, csum_xor: 8'h00, garbage: 0, exp_ok: 1'b1};
      vecs[1] = '{base: 16'h2000, csum_xor: 8'h01, garbage: 0, exp_ok: 1'b0};
      vecs[2] = '{base: 16'h3A50, csum_xor: 8'h00, garbage: 4, exp_ok: 1'b1};
      vecs[3] = '{base: 16'hA5A5, csum_xor: 8'h00, garbage: 1, exp_ok: 1'b1};

      model_img = '0;
      in_data   = 8'h00;
      in_valid  = 1'b0;
      reset_n   = 1'b0;
      repeat (2) @(posedge clock);
      #2 reset_n = 1'b1;
      @(negedge clock);
      chk("rst_image", code_image, 256'(0));
      chk("rst_ready", 256'(in_ready), 256'(1));
      chk("rst_hold", 256'(cpu_hold), 256'(0));
      chk("rst_err", 256'(load_err), 256'(0));
      chk("rst_done", 256'(load_done), 256'(0));
      @(posedge clock); #1;

      for (int i = 0; i < 4; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

      // Stall for the full timeout: frame abandoned, image kept.
      make_frame(16'h6000, 8'h00);
      send_range(0, 10);
      in_valid = 1'b0;
      repeat (T - 1) @(posedge clock);
      #1;
      chk("to_hold_before", 256'(cpu_hold), 256'(1));
      @(posedge clock); #1;
      chk("to_hold_after", 256'(cpu_hold), 256'(0));
      chk("to_err", 256'(load_err), 256'(1));
      chk("to_image", code_image, model_img);
      sb_check("to");

      // Stall one cycle short of the timeout, then finish the frame.
      make_frame(16'h7000, 8'h00);
      send_range(0, 10);
      in_valid = 1'b0;
      repeat (T - 1) @(posedge clock);
      #1;
      exp_q.push_back(img_of(16'h7000));
      send_range(11, 33);
      in_valid = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      model_img = img_of(16'h7000);
      chk("stall_err", 256'(load_err), 256'(0));
      chk("stall_image", code_image, model_img);
      sb_check("stall");

      // Back-to-back frames: next START offered during the commit cycle.
      make_frame(16'h8000, 8'h00);
      exp_q.push_back(img_of(16'h8000));
      send_range(0, 33);
      chk("b2b_ready_commit", 256'(in_ready), 256'(0));
      make_frame(16'h9000, 8'h00);
      exp_q.push_back(img_of(16'h9000));
      send_range(0, 33);
      in_valid = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      model_img = img_of(16'h9000);
      chk("b2b_image", code_image, model_img);
      sb_check("b2b");

      // Asynchronous reset while data byte 20 is on the bus.
      make_frame(16'h4000, 8'h00);
      send_range(0, 19);
      in_data  = fb[20];
      in_valid = 1'b1;
      #3 reset_n = 1'b0;
      #1;
      chk("arst_image", code_image, 256'(0));
      chk("arst_hold", 256'(cpu_hold), 256'(0));
      chk("arst_ready", 256'(in_ready), 256'(1));
      chk("arst_err", 256'(load_err), 256'(0));
      chk("arst_done", 256'(load_done), 256'(0));
      in_valid = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      model_img = '0;
      @(posedge clock); #1;
      sb_check("arst");
      run_vec("post_rst", '{base: 16'h5000, csum_xor: 8'h00, garbage: 0, exp_ok: 1'b1});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
